// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing constants and timer sizing for the
// VGA PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_TIMEOUT = 100000;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_NUM_DOMAINS  = 4;
    localparam int DEF_STAGGER      = 8;
    localparam int DEF_MAX_RETRIES  = 3;

    // Width needed for the shared timer to reach the largest terminal count.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous level signals into the
// local clock domain; resets to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// VGA PLL reset sequencer: PLL reset/lock handling with retry, lock qualification
// and staggered domain reset release. Define PLL_RESET_SEQUENCER_STATUS_EN for status outputs.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
    parameter int STAGGER      = DEF_STAGGER,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
    parameter int CNT_W        = timer_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE,
                                             STAGGER * NUM_DOMAINS)
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    input  logic                   restart_req,
    output logic                   restart_ack,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   ready,
    output logic                   fault,
    output logic [1:0]             retry_cnt
`ifdef PLL_RESET_SEQUENCER_STATUS_EN
    ,
    output logic [15:0]            lock_loss_cnt,
    output logic [2:0]             state_o
`endif
);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((NUM_DOMAINS - 1) * STAGGER);
    localparam logic [1:0]       MAX_R     = 2'(MAX_RETRIES);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic [1:0]             retry_q, retry_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic [NUM_DOMAINS-1:0] release_mask;
    logic                   pll_rst_q, pll_rst_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic                   ack_q, ack_d;
    logic                   locked_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        ack_d   = 1'b0;
        // Timer saturates so the long-lived RUN/FAULT states never wrap it.
        timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
        if (restart_req && state_q != RESET) begin
            ack_d   = 1'b1;
            retry_d = '0;
            state_d = RESET;
        end else begin
            case (state_q)
                RESET: begin
                    if (timer_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                    end else if (timer_q == TO_LAST) begin
                        if (retry_q < MAX_R) begin
                            retry_d = retry_q + 2'd1;
                            state_d = RESET;
                        end else begin
                            state_d = FAULT;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s)                  state_d = WAIT_LOCK;
                    else if (timer_q == STAB_LAST)  state_d = RELEASE;
                end
                RELEASE: begin
                    if (!locked_s)                  state_d = RESET;
                    else if (timer_q == REL_LAST)   state_d = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        retry_d = '0;
                        state_d = RESET;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = RESET;
            endcase
        end
        if (state_d != state_q) timer_d = '0;
    end

    // Domain k is out of reset once the RELEASE timer reaches k*STAGGER.
    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_release
        assign release_mask[gi] = (timer_d >= CNT_W'(gi * STAGGER));
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        pll_rst_d = (state_d == RESET) || (state_d == FAULT);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
        dom_d     = '0;
        if (state_d == RUN)          dom_d = '1;
        else if (state_d == RELEASE) dom_d = release_mask;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET;
            timer_q   <= '0;
            retry_q   <= '0;
            dom_q     <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            dom_q     <= dom_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            ack_q     <= ack_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign restart_ack = ack_q;
    assign dom_rst_n   = dom_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_cnt   = retry_q;

`ifdef PLL_RESET_SEQUENCER_STATUS_EN
    logic [15:0] loss_q, loss_d;

    // Only lock loss out of RUN counts; a restart in the same cycle takes priority.
    always_comb begin
        loss_d = loss_q;
        if (state_q == RUN && !locked_s && !restart_req && loss_q != 16'hFFFF)
            loss_d = loss_q + 16'd1;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) loss_q <= '0;
        else        loss_q <= loss_d;
    end

    assign lock_loss_cnt = loss_q;
    assign state_o       = state_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized/directed bench for pll_reset_sequencer against a cycle-level
// behavioural model of the sequencing rules.
module tb_pll_reset_sequencer;

    localparam int RSTC = 4;
    localparam int TO   = 20;
    localparam int LS   = 8;
    localparam int STG  = 2;
    localparam int ND   = 4;
    localparam int MAXR = 2;

    localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RELEASE = 3, P_RUN = 4, P_FAULT = 5;

    logic          refclk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          pll_rst;
    logic          restart_req;
    logic          restart_ack;
    logic [ND-1:0] dom_rst_n;
    logic          ready;
    logic          fault;
    logic [1:0]    retry_cnt;
`ifdef PLL_RESET_SEQUENCER_STATUS_EN
    logic [15:0]   lock_loss_cnt;
    logic [2:0]    state_o;
`endif

    int total = 0;
    int bad   = 0;
    string scen = "reset";

    // Behavioural model state
    int m_phase, m_t, m_retry, m_loss;
    bit m_ack, m_s1, m_s2;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_CYCLES   (RSTC),
        .LOCK_TIMEOUT (TO),
        .LOCK_STABLE  (LS),
        .NUM_DOMAINS  (ND),
        .STAGGER      (STG),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .restart_req (restart_req),
        .restart_ack (restart_ack),
        .dom_rst_n   (dom_rst_n),
        .ready       (ready),
        .fault       (fault),
        .retry_cnt   (retry_cnt)
`ifdef PLL_RESET_SEQUENCER_STATUS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt),
        .state_o       (state_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_RESET; m_t = 0; m_retry = 0; m_loss = 0;
        m_ack = 0; m_s1 = 0; m_s2 = 0;
    endtask

    // One rising edge of the reference clock, applied to the model.
    task automatic model_step();
        int nxt;
        bit ls;
        ls    = m_s2;
        nxt   = m_phase;
        m_ack = 0;
        if (restart_req && m_phase != P_RESET) begin
            m_ack = 1; m_retry = 0; nxt = P_RESET;
        end else if (m_phase == P_RESET) begin
            if (m_t + 1 == RSTC) nxt = P_WAIT;
        end else if (m_phase == P_WAIT) begin
            if (ls) nxt = P_STABLE;
            else if (m_t + 1 == TO) begin
                if (m_retry < MAXR) begin m_retry++; nxt = P_RESET; end
                else nxt = P_FAULT;
            end
        end else if (m_phase == P_STABLE) begin
            if (!ls) nxt = P_WAIT;
            else if (m_t + 1 == LS) nxt = P_RELEASE;
        end else if (m_phase == P_RELEASE) begin
            if (!ls) nxt = P_RESET;
            else if (m_t == (ND - 1) * STG) nxt = P_RUN;
        end else if (m_phase == P_RUN) begin
            if (!ls) begin
                m_retry = 0;
                if (m_loss < 65535) m_loss++;
                nxt = P_RESET;
            end
        end
        if (nxt != m_phase) begin m_phase = nxt; m_t = 0; end
        else m_t++;
        m_s2 = m_s1;
        m_s1 = pll_locked;
    endtask

    task automatic check_outputs();
        int n, mask;
        mask = 0;
        if (m_phase == P_RUN) mask = (1 << ND) - 1;
        else if (m_phase == P_RELEASE) begin
            n = m_t / STG + 1;
            if (n > ND) n = ND;
            mask = (1 << n) - 1;
        end
        chk({scen, ".pll_rst"}, 32'(pll_rst), 32'(m_phase == P_RESET || m_phase == P_FAULT));
        chk({scen, ".dom_rst_n"}, 32'(dom_rst_n), 32'(mask));
        chk({scen, ".ready"}, 32'(ready), 32'(m_phase == P_RUN));
        chk({scen, ".fault"}, 32'(fault), 32'(m_phase == P_FAULT));
        chk({scen, ".restart_ack"}, 32'(restart_ack), 32'(m_ack));
        chk({scen, ".retry_cnt"}, 32'(retry_cnt), 32'(m_retry));
`ifdef PLL_RESET_SEQUENCER_STATUS_EN
        chk({scen, ".lock_loss_cnt"}, 32'(lock_loss_cnt), 32'(m_loss));
        chk({scen, ".state_o"}, 32'(state_o), 32'(m_phase));
`endif
    endtask

    task automatic cycle();
        @(posedge refclk);
        if (rst_n) model_step();
        @(negedge refclk);
        check_outputs();
    endtask

    task automatic wait_phase(input int target, input int budget);
        int n;
        n = 0;
        while (m_phase != target && n < budget) begin
            cycle();
            n++;
        end
        if (m_phase != target) begin
            total++; bad++;
            $display("FAIL %s.wait_phase @%0t got=%0d exp=%0d", scen, $time, m_phase, target);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, ".dom_rst_n"}, 32'(dom_rst_n), 32'd0);
        chk({tag, ".ready"}, 32'(ready), 32'd0);
        chk({tag, ".fault"}, 32'(fault), 32'd0);
        chk({tag, ".restart_ack"}, 32'(restart_ack), 32'd0);
        chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'd0);
    endtask

    initial begin
        int cnt, n, falls;
        bit prev;

        rst_n = 1'b0; pll_locked = 1'b0; restart_req = 1'b0;
        model_reset();
        #12;
        check_reset_values("por");
        @(negedge refclk);
        rst_n = 1'b1;

        // 1. Nominal bring-up
        scen = "nominal";
        cnt = pll_rst ? 1 : 0;
        n = 0;
        while (pll_rst && n < 50) begin
            cycle();
            if (pll_rst) cnt++;
            n++;
        end
        chk("nominal.pll_rst_len", 32'(cnt), 32'(RSTC));
        repeat (5) cycle();
        pll_locked = 1'b1;
        wait_phase(P_RUN, 100);
        chk("nominal.ready", 32'(ready), 32'd1);
        chk("nominal.dom_all", 32'(dom_rst_n), 32'hF);
        chk("nominal.retry", 32'(retry_cnt), 32'd0);
        $display("scenario nominal: dom=%b ready=%0d", dom_rst_n, ready);

        // 4. Loss of lock in RUN
        scen = "loss_run";
        repeat (3) cycle();
        pll_locked = 1'b0;
        cycle(); cycle();
        chk("loss_run.ready_hold", 32'(ready), 32'd1);
        cycle();
        chk("loss_run.dom", 32'(dom_rst_n), 32'd0);
        chk("loss_run.ready", 32'(ready), 32'd0);
        chk("loss_run.pll_rst", 32'(pll_rst), 32'd1);
        $display("scenario loss_run: dom=%b pll_rst=%0d", dom_rst_n, pll_rst);

        // 2. Timeout with retries then FAULT (lock stays low)
        scen = "timeout";
        falls = 0; n = 0;
        while (!fault && n < 200) begin
            prev = pll_rst;
            cycle();
            if (prev && !pll_rst) falls++;
            n++;
        end
        chk("timeout.fault", 32'(fault), 32'd1);
        chk("timeout.pulses", 32'(falls), 32'd3);
        chk("timeout.retry", 32'(retry_cnt), 32'(MAXR));
        chk("timeout.dom", 32'(dom_rst_n), 32'd0);
        repeat (5) cycle();
        $display("scenario timeout: fault=%0d retries=%0d pulses=%0d", fault, retry_cnt, falls);

        // 5a. Restart from FAULT
        scen = "restart_fault";
        restart_req = 1'b1;
        cycle();
        restart_req = 1'b0;
        chk("restart_fault.ack", 32'(restart_ack), 32'd1);
        chk("restart_fault.fault", 32'(fault), 32'd0);
        chk("restart_fault.retry", 32'(retry_cnt), 32'd0);
        cycle();
        chk("restart_fault.ack_once", 32'(restart_ack), 32'd0);
        $display("scenario restart_fault: fault=%0d retry=%0d", fault, retry_cnt);

        // 3. Glitchy lock
        scen = "glitch";
        wait_phase(P_WAIT, 20);
        pll_locked = 1'b1;
        repeat (5) cycle();
        pll_locked = 1'b0;
        cycle();
        pll_locked = 1'b1;
        n = 0;
        while (!dom_rst_n[0] && n < 40) begin
            cycle();
            n++;
        end
        chk("glitch.release_latency", 32'(n), 32'd11);
        $display("scenario glitch: release after %0d cycles", n);

        // 5b. Restart mid-RELEASE
        scen = "restart_release";
        cycle(); cycle();
        restart_req = 1'b1;
        cycle();
        restart_req = 1'b0;
        chk("restart_release.ack", 32'(restart_ack), 32'd1);
        chk("restart_release.dom", 32'(dom_rst_n), 32'd0);
        chk("restart_release.retry", 32'(retry_cnt), 32'd0);
        cycle();
        chk("restart_release.ack_once", 32'(restart_ack), 32'd0);
        $display("scenario restart_release: dom=%b ack=%0d", dom_rst_n, restart_ack);

        // 6. Asynchronous reset mid-RELEASE
        scen = "async_rst";
        wait_phase(P_RELEASE, 60);
        cycle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        cycle(); cycle();
        rst_n = 1'b1;
        wait_phase(P_RUN, 80);
        chk("async_rst.ready", 32'(ready), 32'd1);
        chk("async_rst.dom", 32'(dom_rst_n), 32'hF);
        $display("scenario async_rst: resequenced ready=%0d", ready);

        // 7. Random lock flapping and restart requests
        scen = "random";
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) pll_locked = ~pll_locked;
            restart_req = ($urandom_range(0, 199) == 0);
            cycle();
        end
        restart_req = 1'b0;
        $display("scenario random: 1500 cycles, phase=%0d", m_phase);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
